// File: rtl/axi_lite_cfg_master.sv
// rtl/axi_lite_cfg_master.sv - single-command AXI4-Lite master for register configuration
// One command in flight; each bus phase is guarded by a timeout that forces an error response.
module axi_lite_cfg_master #(
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int          C_M_AXI_ADDR_WIDTH = 12,
    parameter logic [31:0] C_BASE_ADDRESS     = 32'h00000000,
    parameter int          C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,

    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY,

    output logic                              busy
);

    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam int DW    = C_M_AXI_DATA_WIDTH;
    localparam int SW    = C_M_AXI_DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(C_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0]    ADDR_MASK = {{(AW-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_RSP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_timeout;

    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic [SW-1:0]    r_wstrb;
    logic             r_aw_done;
    logic             r_w_done;
    logic [CNT_W-1:0] r_cnt;
    logic [DW-1:0]    r_rsp_rdata;
    logic [1:0]       r_rsp_resp;
    logic             r_rsp_timeout;
    logic             r_rst_done;

    logic             w_accept;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_b_hs;
    logic             w_ar_hs;
    logic             w_r_hs;
    logic             w_rsp_hs;
    logic             w_expired;
    logic             w_waiting;
    logic [AW-1:0]    w_bus_addr;

    // Handshake outputs are decoded from registered state only, so no VALID follows a READY.
    assign M_AXI_AWVALID = (r_state == S_WR) && !r_aw_done;
    assign M_AXI_WVALID  = (r_state == S_WR) && !r_w_done;
    assign M_AXI_BREADY  = (r_state == S_WR_RESP);
    assign M_AXI_ARVALID = (r_state == S_RD_ADDR);
    assign M_AXI_RREADY  = (r_state == S_RD_DATA);
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;

    assign cmd_ready   = (r_state == S_IDLE) && r_rst_done;
    assign busy        = (r_state != S_IDLE);
    assign rsp_valid   = (r_state == S_RSP);
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_timeout = r_rsp_timeout;

    assign w_accept   = cmd_valid && cmd_ready;
    assign w_aw_hs    = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_w_hs     = M_AXI_WVALID  && M_AXI_WREADY;
    assign w_b_hs     = M_AXI_BVALID  && M_AXI_BREADY;
    assign w_ar_hs    = M_AXI_ARVALID && M_AXI_ARREADY;
    assign w_r_hs     = M_AXI_RVALID  && M_AXI_RREADY;
    assign w_rsp_hs   = rsp_valid && rsp_ready;
    assign w_expired  = (r_cnt == CNT_LAST);
    assign w_waiting  = busy && (r_state != S_RSP);
    assign w_bus_addr = (cmd_addr ^ C_BASE_ADDRESS[AW-1:0]) & ADDR_MASK;

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = cmd_write ? S_WR : S_RD_ADDR;
                end
            end
            S_WR: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_next = S_WR_RESP;
                end else if (!w_aw_hs && !w_w_hs && w_expired) begin
                    w_timeout = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (w_b_hs) begin
                    w_state_next = S_RSP;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                end
            end
            S_RD_ADDR: begin
                if (w_ar_hs) begin
                    w_state_next = S_RD_DATA;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (w_r_hs) begin
                    w_state_next = S_RSP;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                end
            end
            S_RSP: begin
                if (w_rsp_hs) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_timeout) begin
            w_state_next = S_RSP;
        end
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_cnt         <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
            r_rst_done    <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;

            if (w_accept) begin
                r_addr    <= w_bus_addr;
                r_wdata   <= cmd_wdata;
                r_wstrb   <= cmd_wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_done <= 1'b1;
                end
                if (w_w_hs) begin
                    r_w_done <= 1'b1;
                end
            end

            // Each AW/W handshake is progress, so the write-address/data phase restarts its budget.
            if ((w_state_next != r_state) || w_aw_hs || w_w_hs) begin
                r_cnt <= '0;
            end else if (w_waiting) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_timeout) begin
                r_rsp_rdata   <= '0;
                r_rsp_resp    <= 2'b10;
                r_rsp_timeout <= 1'b1;
            end else if (w_b_hs) begin
                r_rsp_rdata   <= '0;
                r_rsp_resp    <= M_AXI_BRESP;
                r_rsp_timeout <= 1'b0;
            end else if (w_r_hs) begin
                r_rsp_rdata   <= M_AXI_RDATA;
                r_rsp_resp    <= M_AXI_RRESP;
                r_rsp_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// tb/tb_axi_lite_cfg_master.sv - randomized bench for axi_lite_cfg_master
// Slave latencies drive a phase-timing model that predicts every cycle's handshake outputs.
module tb_axi_lite_cfg_master;

    localparam int          T        = 8;
    localparam logic [31:0] BASE     = 32'h0000_0A57;
    localparam logic [11:0] BASE_LO  = 12'hA57;

    logic        clk;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [11:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    axi_lite_cfg_master #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (12),
        .C_BASE_ADDRESS     (BASE),
        .C_TIMEOUT_CYCLES   (T)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESET  (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic logic [11:0] bus_addr(input logic [11:0] off);
        return (off ^ BASE_LO) & 12'hFFC;
    endfunction

    function automatic logic [7:0] ctrl_vec();
        return {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy, cmd_ready};
    endfunction

    task automatic clear_slave();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        rsp_ready = 1'b0; cmd_valid = 1'b0;
    endtask

    // Delays count cycles of READY/VALID withheld by the slave; rst_at >= 0 aborts with reset.
    task automatic run_txn(input bit wr, input logic [11:0] off, input logic [31:0] wd,
                           input logic [3:0] ws, input int aw_d, input int w_d, input int b_d,
                           input int ar_d, input int r_d, input int hold,
                           input logic [1:0] sresp, input logic [31:0] srdata, input int rst_at);
        int a, w, s, f, ar, h, hr, t, rsp_t, both_t, ar_t;
        bit to, aw_ok, w_ok, b_ok, ar_ok, r_ok;
        bit pv_aw, pv_w, pv_b, pv_ar, pv_r;
        logic [7:0]  expv;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;

        a = aw_d + 1; w = w_d + 1; ar = ar_d + 1;
        f = imin(a, w); s = imax(a, w);
        to = 1'b0;
        if (wr) begin
            if (f > T)            begin to = 1'b1; h = T;     end
            else if (s - f > T)   begin to = 1'b1; h = f + T; end
            else if (b_d + 1 > T) begin to = 1'b1; h = s + T; end
            else                  h = s + b_d + 1;
        end else begin
            if (ar > T)           begin to = 1'b1; h = T;      end
            else if (r_d + 1 > T) begin to = 1'b1; h = ar + T; end
            else                  h = ar + r_d + 1;
        end
        hr      = h + hold + 1;
        e_resp  = to ? 2'b10 : sresp;
        e_rdata = (to || wr) ? 32'h0 : srdata;

        cmd_write = wr; cmd_addr = off; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge clk); #1;

        t = 0; rsp_t = -1; both_t = -1; ar_t = -1;
        aw_ok = 0; w_ok = 0; b_ok = 0; ar_ok = 0; r_ok = 0;
        pv_aw = 0; pv_w = 0; pv_b = 0; pv_ar = 0; pv_r = 0;
        while (t <= 300) begin
            if (pv_aw && awready) aw_ok = 1;
            if (pv_w && wready)   w_ok = 1;
            if (aw_ok && w_ok && both_t < 0) both_t = t;
            if (pv_b && bvalid)   b_ok = 1;
            if (pv_ar && arready) begin ar_ok = 1; ar_t = t; end
            if (pv_r && rvalid)   r_ok = 1;

            if (t >= hr) begin
                expv = 8'b0000_0001;
            end else begin
                expv = {wr && (t < imin(a, h)), wr && (t < imin(w, h)),
                        wr && (t >= s) && (t < h), !wr && (t < imin(ar, h)),
                        !wr && (t >= ar) && (t < h), t >= h, 1'b1, 1'b0};
            end
            check("ctrl", ctrl_vec(), expv);
            if (awvalid) check("awaddr", awaddr, bus_addr(off));
            if (wvalid) begin
                check("wdata", wdata, wd);
                check("wstrb", wstrb, ws);
            end
            if (arvalid) check("araddr", araddr, bus_addr(off));
            if (rsp_valid) begin
                check("rsp_rdata", rsp_rdata, e_rdata);
                check("rsp_resp", rsp_resp, e_resp);
                check("rsp_timeout", rsp_timeout, to);
                if (rsp_t < 0) rsp_t = t;
            end

            if (t == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check("rst_ctrl", ctrl_vec(), 8'h00);
                check("rst_awaddr", awaddr, 12'h0);
                check("rst_wdata", wdata, 32'h0);
                check("rst_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 35'h0);
                clear_slave();
                return;
            end
            if (t >= hr) break;

            pv_aw = awvalid; pv_w = wvalid; pv_b = bready; pv_ar = arvalid; pv_r = rready;
            awready   = !aw_ok && (t >= aw_d);
            wready    = !w_ok && (t >= w_d);
            bvalid    = (both_t >= 0) && !b_ok && (t >= both_t + b_d);
            bresp     = sresp;
            arready   = !ar_ok && (t >= ar_d);
            rvalid    = (ar_t >= 0) && !r_ok && (t >= ar_t + r_d);
            rdata     = srdata;
            rresp     = sresp;
            rsp_ready = rsp_valid && (t - rsp_t >= hold);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = 12'($urandom);
            cmd_wdata = $urandom;
            cmd_wstrb = 4'($urandom);
            @(posedge clk); #1;
            t++;
        end
        if (t > 300) check("txn_bound", 1'b0, 1'b1);
        clear_slave();
    endtask

    initial begin
        rst = 1'b1;
        clear_slave();
        cmd_write = 1'b0; cmd_addr = 12'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", ctrl_vec(), 8'h00);
        check("reset_addr", {awaddr, araddr}, 24'h0);
        check("reset_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 35'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", ctrl_vec(), 8'h01);

        run_txn(1, 12'h010, 32'h0000_00FF, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, -1);
        run_txn(0, 12'h000, 32'h0, 4'h0, 0, 0, 0, 3, 3, 0, 2'b00, 32'hDEAD_BEEF, -1);
        run_txn(1, 12'h024, 32'h1234_5678, 4'h3, 3, 1, 1, 0, 0, 0, 2'b00, 32'h0, -1);
        run_txn(1, 12'h028, 32'h8765_4321, 4'hC, 1, 3, 1, 0, 0, 0, 2'b01, 32'h0, -1);
        run_txn(0, 12'h100, 32'h0, 4'h0, 0, 0, 0, 50, 0, 0, 2'b00, 32'h5555_AAAA, -1);
        run_txn(0, 12'h104, 32'h0, 4'h0, 0, 0, 0, 1, 1, 0, 2'b00, 32'h0BAD_F00D, -1);
        run_txn(1, 12'h200, 32'hCAFE_0001, 4'hF, 2, 9, 0, 0, 0, 0, 2'b00, 32'h0, -1);
        run_txn(1, 12'h204, 32'hCAFE_0002, 4'hF, 2, 12, 0, 0, 0, 0, 2'b00, 32'h0, -1);
        run_txn(1, 12'h208, 32'hCAFE_0003, 4'hF, 0, 0, 7, 0, 0, 0, 2'b11, 32'h0, -1);
        run_txn(1, 12'h20C, 32'hCAFE_0004, 4'hF, 0, 0, 8, 0, 0, 0, 2'b00, 32'h0, -1);
        run_txn(0, 12'h300, 32'h0, 4'h0, 0, 0, 0, 7, 7, 0, 2'b10, 32'h1357_9BDF, -1);
        run_txn(0, 12'h304, 32'h0, 4'h0, 0, 0, 0, 8, 0, 0, 2'b00, 32'h1, -1);
        run_txn(1, 12'h3F0, 32'hA5A5_5A5A, 4'h5, 1, 2, 2, 0, 0, 5, 2'b00, 32'h0, -1);

        run_txn(1, 12'h040, 32'hFFFF_0000, 4'hF, 0, 0, 6, 0, 0, 0, 2'b00, 32'h0, 3);
        repeat (2) @(posedge clk);
        #1;
        check("in_reset_ctrl", ctrl_vec(), 8'h00);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("release_ctrl", ctrl_vec(), 8'h01);
        run_txn(0, 12'h004, 32'h0, 4'h0, 0, 0, 0, 1, 2, 1, 2'b00, 32'h7654_3210, -1);

        for (int i = 0; i < 120; i++) begin
            run_txn(1'($urandom_range(0, 1)), 12'($urandom), $urandom, 4'($urandom),
                    $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 5),
                    2'($urandom), $urandom, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
